hl_neuron_ctrl: RTL and testbench
=================================

# hl_neuron_ctrl

Sequencer for the MNIST hidden layer that feeds the hidden-layer MAC PE (`PE_hl_mac`: `ofmap = psum + ifmap*weight`) and consumes its result. For each hidden neuron it streams N_IN pixel/weight pairs from synchronous memories into the PE and seeds the accumulation with the neuron's bias. It then applies ReLU, right-shift requantisation and unsigned 8-bit saturation, and presents the activation to the output-layer buffer over a valid/ready handshake.

## Interface
- N_IN, 784, inputs per neuron (pixels)
- N_HID, 64, hidden neurons per image
- SHIFT, 8, requantisation right-shift
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a full layer pass (ignored while busy)
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last neuron's output handshake
- in_addr  out  clog2(N_IN)  pixel memory address
- in_data  in  8  unsigned pixel; valid 1 cycle after address
- w_addr  out  clog2(N_IN*N_HID)  weight address = neuron*N_IN + k (running counter, no multiplier)
- w_data  in  8  signed weight; valid 1 cycle after address
- rd_en  out  1  read enable for pixel/weight memories
- b_addr  out  clog2(N_HID)  bias address = current neuron index
- b_data  in  32  signed bias; valid 1 cycle after address
- pe_ifmap / pe_weight  out  8 / 8  to PE (registered memory data)
- pe_psum  out  32  accumulator register to PE
- pe_ofmap  in  32  PE result
- out_valid  out  1  activation available
- out_ready  in  1  downstream accepts
- out_idx  out  clog2(N_HID)  neuron index of out_data
- out_data  out  8  unsigned activation

## Operation
- States: IDLE → BIAS → MAC → DRAIN → POST → OUT → (BIAS for next neuron | IDLE with done).
- IDLE: waits for start; clears neuron counter and weight-address counter.
- BIAS (1 cycle): b_addr = neuron index.
- MAC (N_IN cycles, k=0..N_IN-1): rd_en=1, in_addr=k, w_addr=base+k. First MAC cycle: psum <= b_data. A valid pipe bit delayed one cycle marks returned data; each marked cycle: psum <= pe_ofmap.
- DRAIN (1 cycle): accumulates the final product; rd_en=0.
- POST (1 cycle): out_data <= psum<0 ? 0 : min(psum>>>SHIFT, 255).
- OUT: out_valid=1 until out_valid&&out_ready; then neuron++. If the neuron was N_HID-1 → IDLE and pulse done, else → BIAS.
- Accumulation is 32-bit signed wrap-around; there is no overflow detection. Worst case 784*255*128 fits.
- start while busy is ignored. rst_n low at any point (including mid-MAC or OUT) returns to IDLE within the same cycle; the partial neuron is discarded.

## Timing
- Reset values: busy=0, done=0, rd_en=0, out_valid=0, out_data=0, out_idx=0, in_addr=0, w_addr=0, b_addr=0, pe_psum=0, pe_ifmap=0, pe_weight=0.
- With BIAS as cycle 0, out_valid rises in cycle N_IN+3 at the earliest.
- Per neuron, N_IN+4 cycles with out_ready held high.
- out_data and out_idx are stable while out_valid=1 and out_ready=0.
- done goes high in the cycle after the final handshake; busy drops in that same cycle.

## Structure
- Shared package hl_pkg: PIX_W=8, W_W=8, ACC_W=32, ACT_W=8, and the state enum (IDLE, BIAS, MAC, DRAIN, POST, OUT).
- Sub-module hl_requant: combinational ReLU, shift and saturate; parameter SHIFT; 32→8 bits.
- The bench instantiates the PE alongside this block.

## Test plan
All scenarios use N_IN=4, N_HID=2, SHIFT=8, and memory models with 1-cycle read latency.
- Pixels {130,52,25,255}, weights {-30,70,60,50}, bias 0 → acc 13990, out_data=54, out_idx=0, out_valid in cycle 7 after BIAS.
- Same pixels and weights, bias 256 → acc 14246 → 55. Bias -13990 → 0. Weights all -128 → ReLU gives 0.
- Pixels all 255, weights all 127 → acc 129540 → 506, saturated to 255.
- out_ready held low 5 cycles during OUT → out_valid, out_data and out_idx held constant. Neuron 1 starts only after the handshake; done pulses once after neuron 1 is accepted.
- start pulsed again while busy → ignored, no extra neurons. Two back-to-back passes → identical outputs.
- rst_n asserted during MAC of neuron 1 → all outputs at reset values immediately. A new start then gives the full correct sequence from neuron 0.

Source files
------------

// File: rtl/hl_pkg.sv
// -----------------------------------------------------------------------------
// hl_pkg
// Shared definitions for the MNIST hidden-layer sequencer: datapath widths,
// the sequencer state encoding and an address-width helper.
// -----------------------------------------------------------------------------
package hl_pkg;

    localparam int PIX_W = 8;   // unsigned pixel
    localparam int W_W   = 8;   // signed weight
    localparam int ACC_W = 32;  // signed accumulator / bias
    localparam int ACT_W = 8;   // unsigned activation

    typedef enum logic [2:0] {
        IDLE,
        BIAS,
        MAC,
        DRAIN,
        POST,
        OUT
    } state_t;

    // Address width for a memory of n entries; never returns zero so that
    // degenerate single-entry memories still get a legal 1-bit address.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hl_neuron_ctrl_if.sv
// -----------------------------------------------------------------------------
// hl_neuron_ctrl_if
// Activation stream from the hidden-layer sequencer to the output-layer buffer.
//   out_valid  activation available (master drives)
//   out_ready  downstream accepts   (slave drives)
//   out_idx    neuron index of out_data
//   out_data   unsigned activation
// -----------------------------------------------------------------------------
interface hl_neuron_ctrl_if
    import hl_pkg::*;
#(
    parameter int IDX_W = 6
) ();

    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic [ACT_W-1:0] out_data;

    modport master (
        output out_valid,
        output out_idx,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_idx,
        input  out_data,
        output out_ready
    );

endinterface

// File: rtl/hl_requant.sv
// -----------------------------------------------------------------------------
// hl_requant
// Combinational ReLU, arithmetic right-shift and unsigned saturation.
//   acc  in   signed accumulator
//   act  out  unsigned activation: acc<0 ? 0 : min(acc>>>SHIFT, 2**ACT_W-1)
// -----------------------------------------------------------------------------
module hl_requant
    import hl_pkg::*;
#(
    parameter int SHIFT = 8
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic        [ACT_W-1:0] act
);

    localparam logic signed [ACC_W-1:0] ACT_MAX = ACC_W'((1 << ACT_W) - 1);

    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        shifted = acc >>> SHIFT;
        if (acc < 0) begin
            act = '0;
        end else if (shifted > ACT_MAX) begin
            act = ACT_MAX[ACT_W-1:0];
        end else begin
            act = shifted[ACT_W-1:0];
        end
    end

endmodule

// File: rtl/hl_neuron_ctrl.sv
// -----------------------------------------------------------------------------
// hl_neuron_ctrl
// Hidden-layer sequencer. For every neuron: fetch bias, stream N_IN
// pixel/weight pairs into the external MAC PE, requantise the sum and offer
// the activation on a valid/ready stream.
//   clk, rst_n            clock, asynchronous active-low reset
//   start / busy / done   layer-pass control
//   in_addr/in_data       pixel memory (1-cycle read latency)
//   w_addr/w_data         weight memory, address = neuron*N_IN + k
//   b_addr/b_data         bias memory, address = neuron
//   rd_en                 read enable for pixel/weight memories
//   pe_*                  operands to / result from the MAC PE
//   out_if                activation stream (master side)
// Per neuron: BIAS(1) + MAC(N_IN) + DRAIN(1) + POST(1) + OUT(>=1) cycles.
// -----------------------------------------------------------------------------
module hl_neuron_ctrl
    import hl_pkg::*;
#(
    parameter  int N_IN  = 784,
    parameter  int N_HID = 64,
    parameter  int SHIFT = 8,
    localparam int IN_AW = addr_w(N_IN),
    localparam int W_AW  = addr_w(N_IN * N_HID),
    localparam int N_AW  = addr_w(N_HID)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [IN_AW-1:0]        in_addr,
    input  logic [PIX_W-1:0]        in_data,
    output logic [W_AW-1:0]         w_addr,
    input  logic signed [W_W-1:0]   w_data,
    output logic                    rd_en,
    output logic [N_AW-1:0]         b_addr,
    input  logic signed [ACC_W-1:0] b_data,
    output logic [PIX_W-1:0]        pe_ifmap,
    output logic signed [W_W-1:0]   pe_weight,
    output logic signed [ACC_W-1:0] pe_psum,
    input  logic signed [ACC_W-1:0] pe_ofmap,
    hl_neuron_ctrl_if.master        out_if
);

    state_t                  state, state_nxt;
    logic [IN_AW-1:0]        k;         // pixel index within the neuron
    logic [W_AW-1:0]         w_cnt;     // running weight address, never reset per neuron
    logic [N_AW-1:0]         neuron;
    logic                    valid_d;   // memory data returned this cycle
    logic signed [ACC_W-1:0] psum;
    logic [ACT_W-1:0]        act, act_q;
    logic                    handshake, last_k, last_n;

    assign handshake = (state == OUT) && out_if.out_ready;
    assign last_k    = (k == IN_AW'(N_IN - 1));
    assign last_n    = (neuron == N_AW'(N_HID - 1));

    // NOTE: every register, state included, has an async reset value so an
    // rst_n pulse mid-neuron leaves no stale partial sum or address behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt gets its default before the case so no path can leave
    // it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = BIAS;
            BIAS:    state_nxt = MAC;
            MAC:     if (last_k) state_nxt = DRAIN;
            DRAIN:   state_nxt = POST;
            POST:    state_nxt = OUT;
            OUT:     if (out_if.out_ready) state_nxt = last_n ? IDLE : BIAS;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments keep every register reading the
    // pre-edge value of its neighbours, e.g. psum vs. valid_d.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k       <= '0;
            w_cnt   <= '0;
            neuron  <= '0;
            valid_d <= 1'b0;
            psum    <= '0;
            act_q   <= '0;
            done    <= 1'b0;
        end else begin
            valid_d <= (state == MAC);
            done    <= handshake && last_n;
            case (state)
                IDLE: begin
                    k      <= '0;
                    w_cnt  <= '0;
                    neuron <= '0;
                end
                MAC: begin
                    k     <= last_k ? '0 : k + 1'b1;
                    w_cnt <= w_cnt + 1'b1;
                end
                POST: act_q <= act;
                OUT:  if (out_if.out_ready) neuron <= last_n ? '0 : neuron + 1'b1;
                default: ;
            endcase
            // Bias arrives in the first MAC cycle, one cycle before the first
            // product, so seeding and accumulating never collide.
            if (state == MAC && k == '0) begin
                psum <= b_data;
            end else if (valid_d) begin
                psum <= pe_ofmap;
            end
        end
    end

    hl_requant #(.SHIFT(SHIFT)) u_requant (
        .acc (psum),
        .act (act)
    );

    assign busy             = (state != IDLE);
    assign rd_en            = (state == MAC);
    assign in_addr          = k;
    assign w_addr           = w_cnt;
    assign b_addr           = neuron;
    // Gate memory data so the PE sees zeros outside returned-data cycles.
    assign pe_ifmap         = valid_d ? in_data : '0;
    assign pe_weight        = valid_d ? w_data  : '0;
    assign pe_psum          = psum;
    assign out_if.out_valid = (state == OUT);
    assign out_if.out_idx   = neuron;
    assign out_if.out_data  = act_q;

endmodule

// File: tb/tb_hl_neuron_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hl_neuron_ctrl
// Bench for hl_neuron_ctrl with N_IN=4, N_HID=2, SHIFT=8, 1-cycle-latency
// memory models and an inline MAC PE. Expected activations come from a plain
// arithmetic model of the neuron (bias + sum of products, ReLU, shift, clamp).
// -----------------------------------------------------------------------------
module tb_hl_neuron_ctrl;
    import hl_pkg::*;

    localparam int N_IN    = 4;
    localparam int N_HID   = 2;
    localparam int SHIFT   = 8;
    localparam int IN_AW   = $clog2(N_IN);
    localparam int W_AW    = $clog2(N_IN * N_HID);
    localparam int N_AW    = $clog2(N_HID);
    localparam int TIMEOUT = 50;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    start;
    logic                    busy, done, rd_en;
    logic [IN_AW-1:0]        in_addr;
    logic [7:0]              in_data;
    logic [W_AW-1:0]         w_addr;
    logic signed [7:0]       w_data;
    logic [N_AW-1:0]         b_addr;
    logic signed [31:0]      b_data;
    logic [7:0]              pe_ifmap;
    logic signed [7:0]       pe_weight;
    logic signed [31:0]      pe_psum;
    logic signed [31:0]      pe_ofmap;

    hl_neuron_ctrl_if #(.IDX_W(N_AW)) out_if ();

    hl_neuron_ctrl #(.N_IN(N_IN), .N_HID(N_HID), .SHIFT(SHIFT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .rd_en     (rd_en),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .pe_ifmap  (pe_ifmap),
        .pe_weight (pe_weight),
        .pe_psum   (pe_psum),
        .pe_ofmap  (pe_ofmap),
        .out_if    (out_if)
    );

    always #5 clk = ~clk;

    // Memory contents and synchronous read models.
    logic [7:0]        pix  [N_IN];
    logic signed [7:0] wt   [N_IN*N_HID];
    int                bias [N_HID];
    logic [7:0]        results [N_HID];

    always_ff @(posedge clk) begin
        in_data <= pix[in_addr];
        w_data  <= wt[w_addr];
        b_data  <= bias[b_addr];
    end

    // MAC PE: ofmap = psum + ifmap*weight (ifmap unsigned, weight signed).
    assign pe_ofmap = pe_psum + $signed({1'b0, pe_ifmap}) * pe_weight;

    int checks = 0;
    int errors = 0;

    function automatic int model_acc(input int n);
        int acc = bias[n];
        for (int i = 0; i < N_IN; i++) acc += int'(pix[i]) * int'(wt[n*N_IN + i]);
        return acc;
    endfunction

    function automatic logic [7:0] model_act(input int acc);
        int q;
        if (acc < 0) return 8'd0;
        q = acc / (1 << SHIFT);
        if (q > 255) return 8'd255;
        return q[7:0];
    endfunction

    // One layer pass. stall: cycles out_ready stays low once out_valid rises.
    // poke: hold start high while busy. abort_n: neuron at whose third cycle
    // rst_n is asserted (-1 for none).
    task automatic run_pass(input int stall, input bit poke, input int abort_n);
        int         cyc, exp_acc;
        logic [7:0] exp_act;
        bit         addr_bad, ctl_bad, hold_bad;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL busy_after_start got %b want 1", busy);
        end
        for (int n = 0; n < N_HID; n++) begin
            exp_acc = model_acc(n);
            exp_act = model_act(exp_acc);
            checks++;
            if (b_addr !== N_AW'(n)) begin
                errors++; $display("FAIL b_addr n=%0d got %0d want %0d", n, b_addr, n);
            end
            if (n == abort_n) begin
                repeat (2) @(negedge clk);
                rst_n = 1'b0;
                #1;
                checks++;
                if ({busy, done, rd_en, out_if.out_valid, out_if.out_data, out_if.out_idx,
                     in_addr, w_addr, b_addr, pe_psum, pe_ifmap, pe_weight} !== '0) begin
                    errors++;
                    $display("FAIL reset_mid_mac got %h want 0", {busy, done, rd_en,
                             out_if.out_valid, out_if.out_data, out_if.out_idx, in_addr,
                             w_addr, b_addr, pe_psum, pe_ifmap, pe_weight});
                end
                @(negedge clk); rst_n = 1'b1;
                return;
            end
            cyc = 0; addr_bad = 1'b0; ctl_bad = 1'b0; hold_bad = 1'b0;
            while (out_if.out_valid !== 1'b1 && cyc < TIMEOUT) begin
                if (rd_en !== ((cyc >= 1 && cyc <= N_IN) ? 1'b1 : 1'b0)) addr_bad = 1'b1;
                if (cyc >= 1 && cyc <= N_IN &&
                    (in_addr !== IN_AW'(cyc - 1) || w_addr !== W_AW'(n*N_IN + cyc - 1)))
                    addr_bad = 1'b1;
                if (done !== 1'b0 || busy !== 1'b1) ctl_bad = 1'b1;
                start = poke;
                @(negedge clk);
                cyc++;
            end
            start = 1'b0;
            checks++;
            if (cyc != N_IN + 3) begin
                errors++; $display("FAIL valid_latency n=%0d got %0d want %0d", n, cyc, N_IN + 3);
            end
            checks++;
            if (out_if.out_data !== exp_act) begin
                errors++; $display("FAIL out_data n=%0d got %0d want %0d", n, out_if.out_data, exp_act);
            end
            checks++;
            if (out_if.out_idx !== N_AW'(n)) begin
                errors++; $display("FAIL out_idx got %0d want %0d", out_if.out_idx, n);
            end
            checks++;
            if (pe_psum !== exp_acc) begin
                errors++; $display("FAIL acc n=%0d got %0d want %0d", n, pe_psum, exp_acc);
            end
            checks++;
            if (addr_bad) begin
                errors++; $display("FAIL mac_addr n=%0d got bad rd_en/addr want k sequence", n);
            end
            checks++;
            if (ctl_bad) begin
                errors++; $display("FAIL busy_done_mid n=%0d got glitch want busy=1 done=0", n);
            end
            results[n] = out_if.out_data;
            repeat (stall) begin
                @(negedge clk);
                if (out_if.out_valid !== 1'b1 || out_if.out_data !== exp_act ||
                    out_if.out_idx !== N_AW'(n)) hold_bad = 1'b1;
            end
            if (stall > 0) begin
                checks++;
                if (hold_bad) begin
                    errors++; $display("FAIL backpressure_hold n=%0d got change want stable %0d", n, exp_act);
                end
            end
            out_if.out_ready = 1'b1;
            @(negedge clk);
            out_if.out_ready = 1'b0;
            if (n < N_HID - 1) begin
                checks++;
                if (out_if.out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL after_handshake got v=%b d=%b b=%b want 0 0 1",
                             out_if.out_valid, done, busy);
                end
            end else begin
                checks++;
                if (done !== 1'b1 || busy !== 1'b0) begin
                    errors++; $display("FAIL done_pulse got done=%b busy=%b want 1 0", done, busy);
                end
                hold_bad = 1'b0;
                repeat (8) begin
                    @(negedge clk);
                    if (done !== 1'b0 || busy !== 1'b0 || out_if.out_valid !== 1'b0) hold_bad = 1'b1;
                end
                checks++;
                if (hold_bad) begin
                    errors++; $display("FAIL idle_after_done got activity want idle");
                end
            end
        end
    endtask

    task automatic load_basic(input int b0, input int b1);
        pix = '{8'd130, 8'd52, 8'd25, 8'd255};
        for (int n = 0; n < N_HID; n++) begin
            wt[n*N_IN + 0] = -8'sd30;
            wt[n*N_IN + 1] = 8'sd70;
            wt[n*N_IN + 2] = 8'sd60;
            wt[n*N_IN + 3] = 8'sd50;
        end
        bias[0] = b0;
        bias[1] = b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, rd_en, out_if.out_valid, out_if.out_data, out_if.out_idx,
             in_addr, w_addr, b_addr, pe_psum, pe_ifmap, pe_weight} !== '0) begin
            errors++;
            $display("FAIL reset_values got %h want 0", {busy, done, rd_en, out_if.out_valid,
                     out_if.out_data, out_if.out_idx, in_addr, w_addr, b_addr, pe_psum,
                     pe_ifmap, pe_weight});
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_basic();
        load_basic(0, 256);
        run_pass(0, 1'b0, -1);
        checks++;
        if (results[0] !== 8'd54) begin
            errors++; $display("FAIL basic_bias0 got %0d want 54", results[0]);
        end
        checks++;
        if (results[1] !== 8'd55) begin
            errors++; $display("FAIL basic_bias256 got %0d want 55", results[1]);
        end
    endtask

    task automatic test_relu();
        load_basic(-13990, 0);
        for (int i = 0; i < N_IN; i++) wt[N_IN + i] = -8'sd128;
        run_pass(0, 1'b0, -1);
        checks++;
        if (results[0] !== 8'd0 || results[1] !== 8'd0) begin
            errors++; $display("FAIL relu got %0d,%0d want 0,0", results[0], results[1]);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < N_IN; i++) pix[i] = 8'd255;
        for (int i = 0; i < N_IN*N_HID; i++) wt[i] = 8'sd127;
        bias[0] = 0;
        bias[1] = 0;
        run_pass(0, 1'b0, -1);
        checks++;
        if (results[0] !== 8'd255) begin
            errors++; $display("FAIL saturation got %0d want 255", results[0]);
        end
    endtask

    task automatic test_backpressure();
        load_basic(0, 256);
        run_pass(5, 1'b0, -1);
    endtask

    task automatic test_start_while_busy();
        load_basic(0, 256);
        run_pass(2, 1'b1, -1);
    endtask

    task automatic test_back_to_back();
        load_basic(1000, -500);
        run_pass(0, 1'b0, -1);
        run_pass(0, 1'b0, -1);
    endtask

    task automatic test_reset_mid_mac();
        load_basic(0, 256);
        run_pass(0, 1'b0, 1);
        run_pass(0, 1'b0, -1);
    endtask

    task automatic test_random();
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < N_IN; i++) pix[i] = 8'($urandom);
            for (int i = 0; i < N_IN*N_HID; i++) wt[i] = 8'($urandom);
            for (int n = 0; n < N_HID; n++) bias[n] = int'($urandom_range(60000)) - 30000;
            run_pass(int'($urandom_range(3)), p[0], -1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        out_if.out_ready = 1'b0;
        for (int i = 0; i < N_IN; i++) pix[i] = '0;
        for (int i = 0; i < N_IN*N_HID; i++) wt[i] = '0;
        for (int n = 0; n < N_HID; n++) bias[n] = 0;
        test_reset();
        test_basic();
        test_relu();
        test_saturation();
        test_backpressure();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_mac();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
